// File: rtl/float_mul_frac_iter.sv
// Iterative significand multiplier: radix-2^BPC shift-add producing the exact
// 48-bit product, with the FP side-band fields carried alongside.
module float_mul_frac_iter #(
  parameter int BPC = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  a_rm,
  input  logic        a_sign,
  input  logic        a_is_inf_nan,
  input  logic [9:0]  a_exp10,
  input  logic [22:0] a_inf_nan_frac,
  input  logic [23:0] a_a_frac24,
  input  logic [23:0] a_b_frac24,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:0]  n_rm,
  output logic        n_sign,
  output logic        n_is_inf_nan,
  output logic [9:0]  n_exp10,
  output logic [22:0] n_inf_nan_frac,
  output logic [47:0] n_frac48
);

  localparam int NCYC = 24 / BPC;
  localparam int CW   = $clog2(NCYC + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nxt;
  logic [47:0]     acc, mcand, acc_sum;
  logic [23:0]     mplier;
  logic [CW-1:0]   count;
  logic            accept, short_c, last;

  // One radix-2^BPC digit times the shifted multiplicand.
  function automatic logic [47:0] partial(input logic [47:0] m, input logic [BPC-1:0] d);
    return m * {{(48-BPC){1'b0}}, d};
  endfunction

  assign accept  = in_valid & in_ready;
  assign short_c = a_is_inf_nan | (a_a_frac24 == 24'd0) | (a_b_frac24 == 24'd0);
  assign last    = (count == CW'(NCYC - 1));
  assign acc_sum = acc + partial(mcand, mplier[BPC-1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid) state_nxt = short_c ? DONE : RUN;
      RUN:  if (last) state_nxt = DONE;
      DONE: if (out_ready) begin
        if (in_valid) state_nxt = short_c ? DONE : RUN;
        else          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_rm           <= '0;
      n_sign         <= 1'b0;
      n_is_inf_nan   <= 1'b0;
      n_exp10        <= '0;
      n_inf_nan_frac <= '0;
      n_frac48       <= '0;
      acc            <= '0;
      mcand          <= '0;
      mplier         <= '0;
      count          <= '0;
    end else if (accept) begin
      n_rm           <= a_rm;
      n_sign         <= a_sign;
      n_is_inf_nan   <= a_is_inf_nan;
      n_exp10        <= a_exp10;
      n_inf_nan_frac <= a_inf_nan_frac;
      mcand          <= {24'd0, a_a_frac24};
      mplier         <= a_b_frac24;
      acc            <= '0;
      count          <= '0;
      if (short_c) n_frac48 <= '0;
    end else if (state == RUN) begin
      acc    <= acc_sum;
      mcand  <= mcand << BPC;
      mplier <= mplier >> BPC;
      count  <= count + CW'(1);
      if (last) n_frac48 <= acc_sum;
    end
  end

endmodule

// File: tb/tb_float_mul_frac_iter.sv
// Directed bench for float_mul_frac_iter: latency, products, short-circuit,
// backpressure, random stream, async reset and a BPC sweep.
module tb_float_mul_frac_iter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [1:0]  a_rm, n_rm;
  logic        a_sign, n_sign, a_is_inf_nan, n_is_inf_nan;
  logic [9:0]  a_exp10, n_exp10;
  logic [22:0] a_inf_nan_frac, n_inf_nan_frac;
  logic [23:0] a_a_frac24, a_b_frac24;
  logic [47:0] n_frac48;

  logic        sw_valid;
  logic        one = 1'b1;
  logic        sw_ir [3];
  logic        sw_ov [3];
  logic [1:0]  sw_rm [3];
  logic        sw_sg [3];
  logic        sw_in [3];
  logic [9:0]  sw_e  [3];
  logic [22:0] sw_f  [3];
  logic [47:0] sw_fr [3];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  float_mul_frac_iter #(.BPC(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a_rm(a_rm), .a_sign(a_sign), .a_is_inf_nan(a_is_inf_nan), .a_exp10(a_exp10),
    .a_inf_nan_frac(a_inf_nan_frac), .a_a_frac24(a_a_frac24), .a_b_frac24(a_b_frac24),
    .out_valid(out_valid), .out_ready(out_ready), .n_rm(n_rm), .n_sign(n_sign),
    .n_is_inf_nan(n_is_inf_nan), .n_exp10(n_exp10), .n_inf_nan_frac(n_inf_nan_frac),
    .n_frac48(n_frac48)
  );

  for (genvar g = 0; g < 3; g++) begin : g_sw
    localparam int BV = (g == 0) ? 1 : (g == 1) ? 8 : 24;
    float_mul_frac_iter #(.BPC(BV)) u_sw (
      .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(sw_ir[g]),
      .a_rm(a_rm), .a_sign(a_sign), .a_is_inf_nan(a_is_inf_nan), .a_exp10(a_exp10),
      .a_inf_nan_frac(a_inf_nan_frac), .a_a_frac24(a_a_frac24), .a_b_frac24(a_b_frac24),
      .out_valid(sw_ov[g]), .out_ready(one), .n_rm(sw_rm[g]), .n_sign(sw_sg[g]),
      .n_is_inf_nan(sw_in[g]), .n_exp10(sw_e[g]), .n_inf_nan_frac(sw_f[g]),
      .n_frac48(sw_fr[g])
    );
  end

  typedef struct {
    logic [47:0] frac;
    logic [36:0] side;
  } txn_t;
  txn_t q[$];

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic start_op(input logic [23:0] a, input logic [23:0] b, input logic inf,
                          input logic [22:0] f, input logic [9:0] e, input logic [1:0] rm,
                          input logic sg);
    a_a_frac24 = a; a_b_frac24 = b; a_is_inf_nan = inf; a_inf_nan_frac = f;
    a_exp10 = e; a_rm = rm; a_sign = sg; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Edges after the accept edge until out_valid is seen.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  int lat, sent, rcvd, cyc, ovcnt;
  bit acc_now;
  logic [47:0] hold_frac;
  logic [23:0] ra, rb;
  int sw_lat [3];
  logic [47:0] sw_val [3];
  txn_t t;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; sw_valid = 1'b0;
    a_rm = '0; a_sign = 1'b0; a_is_inf_nan = 1'b0; a_exp10 = '0;
    a_inf_nan_frac = '0; a_a_frac24 = '0; a_b_frac24 = '0;
    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_frac", n_frac48, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // 1.0 * 1.0
    start_op(24'h800000, 24'h800000, 1'b0, 23'h0, 10'd127, 2'd1, 1'b0);
    wait_done(lat);
    chk("one_lat", lat, 6);
    chk("one_frac", n_frac48, 48'h400000000000);
    chk("one_exp", n_exp10, 127);
    chk("one_rm", n_rm, 1);
    @(posedge clk); #1;
    chk("one_idle", out_valid, 0);

    // Max and 0.75-scaled operands
    start_op(24'hFFFFFF, 24'hFFFFFF, 1'b0, 23'h0, 10'd300, 2'd2, 1'b1);
    wait_done(lat);
    chk("max_frac", n_frac48, 48'hFFFFFE000001);
    chk("max_sign", n_sign, 1);
    @(posedge clk); #1;
    start_op(24'hC00000, 24'hC00000, 1'b0, 23'h0, 10'd5, 2'd0, 1'b0);
    wait_done(lat);
    chk("c0_frac", n_frac48, 48'h900000000000);
    @(posedge clk); #1;

    // Special and zero short-circuit: valid in the cycle right after accept
    start_op(24'h912345, 24'hABCDEF, 1'b1, 23'h400000, 10'd255, 2'd3, 1'b1);
    wait_done(lat);
    chk("spc_lat", lat, 0);
    chk("spc_frac", n_frac48, 0);
    chk("spc_nanfrac", n_inf_nan_frac, 23'h400000);
    chk("spc_flag", n_is_inf_nan, 1);
    @(posedge clk); #1;
    start_op(24'h912345, 24'h000000, 1'b0, 23'h0, 10'd100, 2'd0, 1'b0);
    wait_done(lat);
    chk("zero_lat", lat, 0);
    chk("zero_frac", n_frac48, 0);
    @(posedge clk); #1;

    // Backpressure in DONE, then back-to-back accept
    out_ready = 1'b0;
    start_op(24'hFFFFFF, 24'hC00000, 1'b0, 23'h0, 10'd77, 2'd2, 1'b1);
    wait_done(lat);
    chk("bp_frac", n_frac48, 48'hBFFFFF400000);
    hold_frac = n_frac48;
    a_a_frac24 = 24'hC00000; a_b_frac24 = 24'hC00000; a_exp10 = 10'd9;
    a_rm = 2'd1; a_sign = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_frac_hold", n_frac48, hold_frac);
      chk("bp_exp_hold", n_exp10, 77);
    end
    out_ready = 1'b1;
    #1;
    chk("b2b_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("b2b_run", out_valid, 0);
    chk("b2b_exp", n_exp10, 9);
    wait_done(lat);
    chk("b2b_lat", lat, 6);
    chk("b2b_frac", n_frac48, 48'h900000000000);
    @(posedge clk); #1;

    // Random stream with random in_valid / out_ready
    sent = 0; rcvd = 0; cyc = 0;
    while (rcvd < 20 && cyc < 3000) begin
      if (!in_valid && sent < 20 && $urandom_range(0, 2) != 0) begin
        ra = ($urandom_range(0, 9) == 0) ? 24'd0 : {1'b1, 23'($urandom)};
        rb = {1'b1, 23'($urandom)};
        a_a_frac24 = ra; a_b_frac24 = rb;
        a_is_inf_nan = ($urandom_range(0, 7) == 0);
        a_inf_nan_frac = 23'($urandom); a_exp10 = 10'($urandom);
        a_rm = 2'($urandom); a_sign = 1'($urandom);
        in_valid = 1'b1;
      end
      out_ready = 1'($urandom_range(0, 1));
      #1;
      acc_now = in_valid && in_ready;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("stream_extra", 1, 0);
        end else begin
          t = q.pop_front();
          chk("stream_frac", n_frac48, t.frac);
          chk("stream_side", {11'd0, n_rm, n_sign, n_is_inf_nan, n_exp10, n_inf_nan_frac}, {11'd0, t.side});
        end
        rcvd++;
      end
      if (acc_now) begin
        t.frac = a_is_inf_nan ? 48'd0 : 48'(a_a_frac24) * 48'(a_b_frac24);
        t.side = {a_rm, a_sign, a_is_inf_nan, a_exp10, a_inf_nan_frac};
        q.push_back(t);
      end
      @(posedge clk); #1;
      if (acc_now) begin
        in_valid = 1'b0;
        sent++;
      end
      cyc++;
    end
    chk("stream_count", rcvd, 20);
    chk("stream_empty", q.size(), 0);
    out_ready = 1'b1; a_is_inf_nan = 1'b0;
    @(posedge clk); #1;

    // Asynchronous reset in the middle of RUN
    start_op(24'h923456, 24'hA5A5A5, 1'b0, 23'h0, 10'd200, 2'd1, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", out_valid, 0);
    chk("mrst_exp", n_exp10, 0);
    chk("mrst_sign", n_sign, 0);
    chk("mrst_frac", n_frac48, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    ovcnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid) ovcnt++;
    end
    chk("mrst_no_emit", ovcnt, 0);
    start_op(24'h923456, 24'hA5A5A5, 1'b0, 23'h0, 10'd200, 2'd1, 1'b1);
    wait_done(lat);
    chk("mrst_next_lat", lat, 6);
    chk("mrst_next_frac", n_frac48, 48'(24'h923456) * 48'(24'hA5A5A5));
    @(posedge clk); #1;

    // BPC sweep: 1, 8, 24 bits per cycle
    a_a_frac24 = 24'hABCDEF; a_b_frac24 = 24'h987654; a_is_inf_nan = 1'b0;
    for (int g = 0; g < 3; g++) begin
      sw_lat[g] = -1;
      sw_val[g] = '0;
    end
    sw_valid = 1'b1;
    @(posedge clk); #1;
    sw_valid = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      for (int g = 0; g < 3; g++) begin
        if (sw_ov[g] && sw_lat[g] < 0) begin
          sw_lat[g] = c;
          sw_val[g] = sw_fr[g];
        end
      end
    end
    chk("sw1_lat", 48'(sw_lat[0]), 24);
    chk("sw8_lat", 48'(sw_lat[1]), 3);
    chk("sw24_lat", 48'(sw_lat[2]), 1);
    for (int g = 0; g < 3; g++)
      chk("sw_frac", sw_val[g], 48'(24'hABCDEF) * 48'(24'h987654));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/float_mul_frac_iter.md
Name: float_mul_frac_iter

Overview:
Iterative mantissa-multiply stage of the pipelined FP32 multiplier. It sits directly downstream of the multiply-to-add pipeline register (the a_* signals) and upstream of the normalise/round stage.
- Computes the exact 48-bit product of two 24-bit significands over several cycles using radix-2^BPC shift-add.
- Carries the side-band fields (rm, sign, exp10, inf/nan info) alongside the product.
- Valid/ready handshake on both sides, so upstream can stall the pipeline register (en = in_ready).

Parameters:
BPC, 4, multiplier bits retired per cycle; legal values 1, 2, 3, 4, 6, 8, 12, 24. NCYC = 24/BPC iterations.

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream operands valid
in_ready  output  1  stage can accept; drives upstream register en
a_rm  input  2  rounding mode
a_sign  input  1  product sign
a_is_inf_nan  input  1  result is inf/NaN (special)
a_exp10  input  10  biased exponent sum, two's complement
a_inf_nan_frac  input  23  fraction for special result
a_a_frac24  input  24  significand A (hidden bit included)
a_b_frac24  input  24  significand B (hidden bit included)
out_valid  output  1  result valid
out_ready  input  1  downstream accepts
n_rm  output  2  registered rm
n_sign  output  1  registered sign
n_is_inf_nan  output  1  registered special flag
n_exp10  output  10  registered exponent
n_inf_nan_frac  output  23  registered special fraction
n_frac48  output  48  A*B exact product

Behaviour:
- Reset: clk is the clock; rst_n is the asynchronous, active-low reset.
  - Asserting rst_n low clears state to IDLE, all n_* outputs, the accumulator and the shift registers to 0, and out_valid to 0.
  - Reset mid-RUN discards the operation; nothing is emitted.
- States: IDLE, RUN, DONE.
- in_ready = (state==IDLE) | (state==DONE & out_ready). out_valid = (state==DONE).
- Accept: in_valid & in_ready at a clk edge. On accept:
  - Latch all side-band inputs into n_* fields.
  - mcand <= {24'b0, a_a_frac24}; mplier <= a_b_frac24; acc <= 0; count <= 0.
- Short-circuit: if a_is_inf_nan=1 or either frac24==0 at accept, go straight to DONE with n_frac48=0. Latency is 1 cycle (out_valid high the cycle after accept).
- Otherwise go to RUN.
- RUN, each cycle:
  - acc <= acc + mcand * mplier[BPC-1:0] (48-bit, no overflow possible).
  - mcand <= mcand << BPC; mplier <= mplier >> BPC; count++.
  - After NCYC iterations, n_frac48 <= final acc and state -> DONE.
  - Latency: out_valid first high NCYC cycles after the accept edge (6 for BPC=4).
- DONE: all n_* outputs held stable while out_valid & !out_ready.
- Transfer: out_valid & out_ready. If in_valid is high in the same cycle, the new operand is accepted (back-to-back, no bubble). Otherwise state -> IDLE.
- in_ready is low throughout RUN; in_valid there is ignored and upstream must hold.
- n_* outputs change only on accept (side-band) or RUN completion/short-circuit (n_frac48).
- Between accept and DONE they are not guaranteed meaningful; consumers sample only when out_valid=1.
- in_valid while in IDLE at reset release is accepted at the first edge after rst_n rises.

Test Plan:
1. 1.0*1.0: a=b=24'h800000, sign=0, exp10=10'd127, out_ready=1 → out_valid exactly 6 cycles after accept (BPC=4), n_frac48=48'h400000000000, n_exp10=127.
2. Max operands: a=b=24'hFFFFFF → n_frac48=48'hFFFFFE000001. Also a=b=24'hC00000 → 48'h900000000000.
3. Special/zero short-circuit: a_is_inf_nan=1, a_inf_nan_frac=23'h400000 → out_valid 1 cycle after accept, n_frac48=0, n_inf_nan_frac=23'h400000. Repeat with a_b_frac24=0, same 1-cycle latency.
4. Backpressure: out_ready=0 for 10 cycles in DONE → out_valid stays 1, all n_* stable, in_ready=0, new in_valid not accepted. Then out_ready=1 with in_valid=1 → back-to-back accept in the same cycle.
5. Stream of 20 random operand pairs with random in_valid/out_ready → every n_frac48 matches a*b, side-band fields match per transaction, no loss or duplication; also sweep BPC=1, 8, 24 (latency 24, 3, 1).
6. Reset mid-RUN: assert rst_n low 2 cycles after accept → outputs 0 immediately (async), no out_valid after release, next operation correct.
